// File: rtl/spectrum_averager.sv
// Streaming spectral averager: accumulates 2^navg spectra per bin in an external
// two-port SRAM via a 3-cycle read-modify-write pipeline and emits the block average.
module spectrum_averager #(
  parameter int NBINS    = 2048,
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int NAVG_MAX = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [3:0]    cfg_navg_log2,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_w_en,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_bin,
  output logic          out_last,
  output logic          sat_flag,
  output logic          sync_err
);

  localparam int              SCW        = NAVG_MAX + 1;
  localparam logic [AW-1:0]   LAST_BIN   = AW'(NBINS - 1);
  localparam logic [3:0]      NAVG_CLAMP = 4'(NAVG_MAX);

  typedef enum logic {IDLE, RUN} state_e;

  // Per-sample tags travelling alongside the SRAM read; navg rides along so a
  // re-latch on a framing error cannot change the shift of in-flight samples.
  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [3:0]    navg;
    logic [AW-1:0] bin;
    logic [DW-1:0] data;
  } tag_t;

  state_e          state_q, state_d;
  logic [AW-1:0]   bin_cnt_q, bin_cnt_d;
  logic [SCW-1:0]  spec_cnt_q, spec_cnt_d;
  logic [3:0]      navg_q, navg_d;
  logic            sync_err_d;
  tag_t            tag_d, s1_q, s2_q;

  logic            accept;
  logic [AW-1:0]   acc_bin;
  logic [3:0]      cfg_navg;
  logic [SCW-1:0]  last_cnt;
  logic [DW-1:0]   rd_term;
  logic [DW:0]     sum_full;
  logic [DW-1:0]   sum_sat;
  logic [DW-1:0]   avg;

  assign cfg_navg = (cfg_navg_log2 > NAVG_CLAMP) ? NAVG_CLAMP : cfg_navg_log2;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    bin_cnt_d  = bin_cnt_q;
    spec_cnt_d = spec_cnt_q;
    navg_d     = navg_q;
    sync_err_d = 1'b0;
    accept     = 1'b0;
    acc_bin    = '0;
    tag_d      = '0;

    if (in_valid) begin
      if (state_q == IDLE) begin
        if (in_sof) begin
          accept  = 1'b1;
          state_d = RUN;
          if (spec_cnt_q == '0) navg_d = cfg_navg;
        end
      end else if (in_sof) begin
        accept = 1'b1;
        if (bin_cnt_q != LAST_BIN) begin
          // Short spectrum: restart the block at this sample.
          sync_err_d = 1'b1;
          spec_cnt_d = '0;
          navg_d     = cfg_navg;
        end else if (spec_cnt_q == '0) begin
          navg_d = cfg_navg;
        end
      end else if (bin_cnt_q == LAST_BIN) begin
        sync_err_d = 1'b1;
        state_d    = IDLE;
        spec_cnt_d = '0;
      end else begin
        accept  = 1'b1;
        acc_bin = bin_cnt_q + AW'(1);
      end
    end

    last_cnt = (SCW'(1) << navg_d) - SCW'(1);

    if (accept) begin
      bin_cnt_d   = acc_bin;
      tag_d.valid = 1'b1;
      tag_d.first = (spec_cnt_d == '0);
      tag_d.last  = (spec_cnt_d == last_cnt);
      tag_d.navg  = navg_d;
      tag_d.bin   = acc_bin;
      tag_d.data  = in_data;
      if (acc_bin == LAST_BIN) spec_cnt_d = tag_d.last ? '0 : spec_cnt_d + SCW'(1);
    end
  end

  assign ram_r_addr = RST ? '0 : acc_bin;

  always_comb begin
    rd_term  = s2_q.first ? '0 : ram_r_data;
    sum_full = {1'b0, rd_term} + {1'b0, s2_q.data};
    sum_sat  = sum_full[DW] ? '1 : sum_full[DW-1:0];
    avg      = sum_sat >> s2_q.navg;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      bin_cnt_q  <= '0;
      spec_cnt_q <= '0;
      navg_q     <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      ram_w_addr <= '0;
      ram_w_data <= '0;
      ram_w_en   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bin    <= '0;
      out_last   <= 1'b0;
      sat_flag   <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      bin_cnt_q  <= bin_cnt_d;
      spec_cnt_q <= spec_cnt_d;
      navg_q     <= navg_d;
      s1_q       <= tag_d;
      s2_q       <= s1_q;

      ram_w_en  <= s2_q.valid & ~s2_q.last;
      out_valid <= s2_q.valid & s2_q.last;
      out_last  <= s2_q.valid & s2_q.last & (s2_q.bin == LAST_BIN);

      if (s2_q.valid && !s2_q.last) begin
        ram_w_addr <= s2_q.bin;
        ram_w_data <= sum_sat;
      end
      if (s2_q.valid && s2_q.last) begin
        out_data <= avg;
        out_bin  <= s2_q.bin;
      end

      if (s2_q.valid && sum_full[DW]) sat_flag <= 1'b1;
      if (sync_err_d)                 sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spectrum_averager.sv
// Directed bench for spectrum_averager: vector table of averaging blocks plus
// hand-written framing-error and mid-block reset sequences, with an SRAM model.
module tb_spectrum_averager;

  localparam int NB = 2048;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  cfg_navg_log2 = '0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [31:0] in_data = '0;
  logic [10:0] ram_r_addr;
  logic [31:0] ram_r_data;
  logic [10:0] ram_w_addr;
  logic [31:0] ram_w_data;
  logic        ram_w_en;
  logic        out_valid;
  logic [31:0] out_data;
  logic [10:0] out_bin;
  logic        out_last;
  logic        sat_flag;
  logic        sync_err;

  spectrum_averager dut (
    .CLK(CLK), .RST(RST), .cfg_navg_log2(cfg_navg_log2),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
    .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data), .ram_w_en(ram_w_en),
    .out_valid(out_valid), .out_data(out_data), .out_bin(out_bin), .out_last(out_last),
    .sat_flag(sat_flag), .sync_err(sync_err)
  );

  always #5 CLK = ~CLK;

  // Two-port SRAM with registered output: read data two cycles after the address.
  logic [31:0] mem [NB];
  logic [31:0] rd1 = '0;
  initial ram_r_data = '0;
  always @(posedge CLK) begin
    // NOTE: the array is not reset; the first spectrum of a block never uses read data.
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    rd1        <= mem[ram_r_addr];
    ram_r_data <= rd1;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Expected pipeline event per accepted sample: a write or an averaged output.
  typedef struct packed {
    int          cyc;
    logic        is_out;
    logic [10:0] bin;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  logic [31:0] acc_m [NB];

  always @(negedge CLK) begin
    if (out_valid || ram_w_en) begin
      check("valid_wen_exclusive", 64'(out_valid & ram_w_en), 64'd0);
      check("event_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check($sformatf("latency bin %0d", mon_e.bin), 64'(cyc - mon_e.cyc), 64'd3);
        check($sformatf("event_is_out bin %0d", mon_e.bin), 64'(out_valid), 64'(mon_e.is_out));
        if (mon_e.is_out) begin
          check($sformatf("out_data bin %0d", mon_e.bin), 64'(out_data), 64'(mon_e.val));
          check("out_bin", 64'(out_bin), 64'(mon_e.bin));
          check($sformatf("out_last bin %0d", mon_e.bin), 64'(out_last), 64'(mon_e.bin == 11'(NB - 1)));
        end else begin
          check("ram_w_addr", 64'(ram_w_addr), 64'(mon_e.bin));
          check($sformatf("ram_w_data bin %0d", mon_e.bin), 64'(ram_w_data), 64'(mon_e.val));
        end
      end
    end else if (exp_q.size() != 0 && (cyc - exp_q[0].cyc) > 3) begin
      check($sformatf("missing event bin %0d latency", exp_q[0].bin), 64'(cyc - exp_q[0].cyc), 64'd3);
      void'(exp_q.pop_front());
    end
  end

  task automatic push(input logic is_out, input int bin, input logic [31:0] val);
    exp_t e;
    e.cyc    = cyc;
    e.is_out = is_out;
    e.bin    = 11'(bin);
    e.val    = val;
    exp_q.push_back(e);
  endtask

  task automatic sample(input logic sof, input logic [31:0] d, input int exp_addr);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(negedge CLK);
    if (exp_addr >= 0) check("ram_r_addr", 64'(ram_r_addr), 64'(exp_addr));
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge CLK); #1;
  endtask

  // One spectrum (or its first nbins bins) of data = base + slope*bin.
  task automatic feed(input int s, input int n, input logic [31:0] base, input int slope,
                      input int nbins, input logic [31:0] out_base, input logic gappy);
    for (int b = 0; b < nbins; b++) begin
      logic [31:0] data;
      logic [32:0] sum;
      if (gappy && $urandom_range(0, 1) == 1) idle_cycle();
      data = base + 32'(slope * b);
      if (s == 0) acc_m[b] = data;
      else begin
        sum      = {1'b0, acc_m[b]} + {1'b0, data};
        acc_m[b] = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      end
      if (s == n - 1) push(1'b1, b, out_base + 32'(slope * b));
      else            push(1'b0, b, acc_m[b]);
      sample(b == 0, data, b);
    end
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    @(posedge CLK); #1;
    exp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    check("rst out_valid",  64'(out_valid),  64'd0);
    check("rst ram_w_en",   64'(ram_w_en),   64'd0);
    check("rst out_data",   64'(out_data),   64'd0);
    check("rst out_bin",    64'(out_bin),    64'd0);
    check("rst out_last",   64'(out_last),   64'd0);
    check("rst ram_w_addr", 64'(ram_w_addr), 64'd0);
    check("rst ram_w_data", 64'(ram_w_data), 64'd0);
    check("rst ram_r_addr", 64'(ram_r_addr), 64'd0);
    check("rst sat_flag",   64'(sat_flag),   64'd0);
    check("rst sync_err",   64'(sync_err),   64'd0);
  endtask

  task automatic drain();
    repeat (6) idle_cycle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct packed {
    logic [3:0]       navg;
    logic [0:3][31:0] d;
    logic [7:0]       slope;
    logic [31:0]      exp_base;
    logic             exp_sat;
    logic             gappy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{navg: 4'd0, d: {32'd0, 32'd0, 32'd0, 32'd0}, slope: 8'd3,
                exp_base: 32'd0, exp_sat: 1'b0, gappy: 1'b0};
    vecs[1] = '{navg: 4'd2, d: {32'd100, 32'd100, 32'd100, 32'd100}, slope: 8'd0,
                exp_base: 32'd100, exp_sat: 1'b0, gappy: 1'b0};
    vecs[2] = '{navg: 4'd1, d: {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd0, 32'd0}, slope: 8'd0,
                exp_base: 32'h7FFF_FFFF, exp_sat: 1'b1, gappy: 1'b0};
    vecs[3] = '{navg: 4'd2, d: {32'd1, 32'd2, 32'd3, 32'd5}, slope: 8'd1,
                exp_base: 32'd2, exp_sat: 1'b0, gappy: 1'b0};
    vecs[4] = '{navg: 4'd1, d: {32'd7, 32'd8, 32'd0, 32'd0}, slope: 8'd2,
                exp_base: 32'd7, exp_sat: 1'b0, gappy: 1'b0};
    vecs[5] = '{navg: 4'd2, d: {32'd100, 32'd100, 32'd100, 32'd100}, slope: 8'd0,
                exp_base: 32'd100, exp_sat: 1'b0, gappy: 1'b1};

    for (int i = 0; i < 6; i++) begin
      int n;
      do_reset();
      cfg_navg_log2 = vecs[i].navg;
      n = 1 << vecs[i].navg;
      for (int s = 0; s < n; s++)
        feed(s, n, vecs[i].d[s], int'(vecs[i].slope), NB, vecs[i].exp_base, vecs[i].gappy);
      drain();
      check($sformatf("vec%0d sat_flag", i), 64'(sat_flag), 64'(vecs[i].exp_sat));
      check($sformatf("vec%0d sync_err", i), 64'(sync_err), 64'd0);
    end

    // Short spectrum: sof at bin 100 of spectrum 1 restarts the block.
    do_reset();
    cfg_navg_log2 = 4'd2;
    feed(0, 4, 32'd10, 1, NB, 32'd0, 1'b0);
    feed(1, 4, 32'd20, 1, 100, 32'd0, 1'b0);
    check("short_sof sync_err before", 64'(sync_err), 64'd0);
    feed(0, 4, 32'd40, 1, NB, 32'd0, 1'b0);
    check("short_sof sync_err after", 64'(sync_err), 64'd1);
    feed(1, 4, 32'd50, 1, NB, 32'd0, 1'b0);
    feed(2, 4, 32'd60, 1, NB, 32'd0, 1'b0);
    feed(3, 4, 32'd70, 1, NB, 32'd55, 1'b0);
    drain();

    // Saturating block interrupted by reset at bin 500 of spectrum 3.
    feed(0, 4, 32'h8000_0000, 0, NB, 32'd0, 1'b0);
    feed(1, 4, 32'h8000_0000, 0, NB, 32'd0, 1'b0);
    feed(2, 4, 32'h8000_0000, 0, NB, 32'd0, 1'b0);
    feed(3, 4, 32'h8000_0000, 0, 500, 32'h3FFF_FFFF, 1'b0);
    check("pre_reset sat_flag", 64'(sat_flag), 64'd1);
    check("pre_reset sync_err", 64'(sync_err), 64'd1);
    do_reset();
    cfg_navg_log2 = 4'd2;
    for (int k = 0; k < 3; k++) sample(1'b0, 32'd99, -1);
    check("idle_drop sync_err", 64'(sync_err), 64'd0);
    for (int s = 0; s < 4; s++) feed(s, 4, 32'd20, 0, NB, 32'd20, 1'b0);
    drain();

    // Missing sof after the last bin: sample dropped, back to IDLE.
    check("no_sof sync_err before", 64'(sync_err), 64'd0);
    sample(1'b0, 32'd5, -1);
    check("no_sof sync_err after", 64'(sync_err), 64'd1);
    sample(1'b0, 32'd6, -1);
    push(1'b0, 0, 32'd8);
    sample(1'b1, 32'd8, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spectrum_averager.md
# spectrum_averager

Streaming spectral averager for the spectrometer data path. It accumulates 2^N consecutive 2048-bin power spectra into the 2048×32 two-port accumulation SRAM using a read-modify-write pipeline. On the final spectrum of each block it emits the averaged spectrum on a valid-qualified output stream. It sits directly upstream of the accumulation SRAM: it drives the write port and the read address, and consumes the read data.

## Interface
Parameters:
- NBINS, 2048: bins per spectrum.
- AW, 11: bin/RAM address width.
- DW, 32: sample, accumulator and RAM data width.
- NAVG_MAX, 10: largest accepted log2 averaging factor.

Ports:
- CLK  in  1  single clock for everything, including the SRAM.
- RST  in  1  reset; synchronous, active-high.
- cfg_navg_log2  in  4  log2 of spectra per block. Values above NAVG_MAX are treated as NAVG_MAX.
- in_valid  in  1  sample strobe; gaps are allowed.
- in_sof  in  1  marks bin 0 of a spectrum; qualified by in_valid.
- in_data  in  DW  unsigned power sample.
- ram_r_addr  out  AW  SRAM read address.
- ram_r_data  in  DW  SRAM read data; 2-cycle latency, because the output register is enabled.
- ram_w_addr  out  AW  SRAM write address.
- ram_w_data  out  DW  SRAM write data.
- ram_w_en  out  1  SRAM write enable.
- out_valid  out  1  averaged bin strobe.
- out_data  out  DW  averaged value.
- out_bin  out  AW  bin index of out_data.
- out_last  out  1  high with bin NBINS-1.
- sat_flag  out  1  sticky; set when an accumulator saturates.
- sync_err  out  1  sticky; set on a framing error.

## Operation
- States:
  - IDLE: waits for the first in_sof; samples without in_sof are dropped.
  - RUN: accepts samples.
- IDLE→RUN on in_valid&in_sof.
  - If spec_cnt==0, this latches navg from cfg_navg_log2 (clamped); navg stays fixed for the whole block.
- Counters:
  - bin_cnt is the bin index of the accepted sample: 0 on in_sof, otherwise previous+1.
  - spec_cnt counts 0..2^navg−1. It increments after bin NBINS−1 and wraps to 0 at the end of a block.
- Per accepted sample, the pipeline tags are:
  - first = (spec_cnt==0)
  - last = (spec_cnt==2^navg−1)
  - bin
  - data
- Read-modify-write path:
  - ram_r_addr = bin_cnt of the accepted sample, driven combinationally in the accept cycle.
  - Tags are delayed 2 cycles to align with ram_r_data.
  - sum = first ? data : ram_r_data + data, computed as a 33-bit add.
  - If bit 32 is set, sum = 2^32−1 and sat_flag is set.
  - If !last: register ram_w_addr=bin, ram_w_data=sum, ram_w_en=1.
  - If last: ram_w_en=0; register out_valid=1, out_data=sum>>navg (logical shift), out_bin=bin, out_last=(bin==NBINS−1).
- navg=0: every spectrum is both first and last. The block is a pure pass-through with latency 3 and never writes the SRAM.
- Framing errors (each sets sync_err):
  - in_sof with bin_cnt≠NBINS−1 in RUN, i.e. a short spectrum: the sample is accepted as bin 0, spec_cnt=0, and navg is re-latched. Partial block contents are discarded by virtue of first=1.
  - in_valid without in_sof after bin NBINS−1: the sample is dropped and the state goes to IDLE with spec_cnt=0.
- Samples already in the pipeline always complete, including any writes or outputs they generate.
- RAM hazard: the same address is re-read no earlier than NBINS accepted samples later, so no forwarding logic is needed.

## Timing
- Accept at cycle t. ram_r_addr is valid in t. ram_r_data is valid in t+2.
- ram_w_*/out_* are registered at the end of t+2 and visible in cycle t+3, so latency is 3 cycles. The SRAM captures the write at the end of t+3.
- out_valid and ram_w_en are single-cycle pulses per accepted sample and are never both high.
- Reset values:
  - all outputs 0
  - state IDLE
  - bin_cnt, spec_cnt and navg 0
  - sat_flag and sync_err cleared
  - pipeline valid bits cleared
- Reset mid-operation: no out_valid or ram_w_en in the cycle after RST is deasserted. The next output only appears after a full new block of 2^navg spectra.
- Flags clear only on RST.

## Test plan
1. navg=0; one spectrum with in_data=3·bin, continuous valid. Required: out_data=3·bin exactly 3 cycles after each input; out_last only with bin 2047; ram_w_en never asserted.
2. navg=2; 4 spectra of constant 100. Required:
   - ram_w_en for every bin of spectra 0–2, with ram_w_data 100, 200, 300 respectively.
   - During spectrum 3: out_data=100 for bins 0..2047, no writes.
3. navg=1; two spectra of 0xFFFF_FFF0. Required: saturated sum 0xFFFF_FFFF, out_data=0x7FFF_FFFF, sat_flag=1.
4. navg=2; in_sof injected at bin 100 of spectrum 1. Required: sync_err=1; a full new 4-spectrum block is needed before the first out_valid; outputs equal the true average of those 4 spectra.
5. navg=2; RST pulsed at bin 500 of spectrum 3. Required: all outputs 0 and flags cleared next cycle; no out_valid until a new sof plus 4 full spectra.
6. Repeat scenario 2 with in_valid randomly 50% duty. Required: identical out_data/out_bin sequence; latency 3 cycles per accepted sample.
